shared_resource_arbiter: RTL

- Responder end of the pipeline arbiter_req/arbiter_grant/resource_input/resource_output handshake.
- Accepts requests from NUM_REQ pipeline instances and grants one requester per cycle, round-robin.
- Pushes the granted operand through a fixed-latency resource pipeline and returns the result with the requester ID.
- Sits between the pipeline_top instances and the shared compute resource at the top level.

---
 rtl/shared_resource_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/shared_resource_arbiter.sv
// Round-robin responder for the arbiter_req/arbiter_grant handshake.
// One operand is granted per advancing cycle. Each granted operand is
// incremented and carried down a fixed-depth stage pipe. The result is
// returned on the output stage together with the index of its requester.
// The whole pipe freezes while the output stage holds a result that
// downstream has not accepted.
module shared_resource_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        arbiter_req,
    input  logic [NUM_REQ*DATA_W-1:0] resource_input,
    output logic [NUM_REQ-1:0]        arbiter_grant,
    output logic [DATA_W-1:0]         resource_output,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    input  logic                      resp_ready,
    output logic                      busy
);

    // After reset the search starts from index 0.
    localparam logic [ID_W-1:0]    RR_RESET    = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]  DATA_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

    // Stage k+1 lives at index k; index LATENCY-1 is the output stage.
    logic [LATENCY-1:0] valid_r;
    logic [ID_W-1:0]    id_r   [LATENCY];
    logic [DATA_W-1:0]  data_r [LATENCY];
    logic [ID_W-1:0]    rr_ptr_r;

    logic               advance_s;
    logic               grant_hit_s;
    logic               grant_fire_s;
    logic               cand_req_s;
    logic [ID_W-1:0]    cand_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [DATA_W-1:0]  operand_s;

    // The pipe moves as a unit whenever the output stage is empty or being drained.
    assign advance_s    = ~valid_r[LATENCY-1] | resp_ready;
    assign grant_fire_s = advance_s & grant_hit_s;

    // Round-robin search.  Scanning from the far end lets the candidate closest to rr_ptr+1 win.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        cand_req_s  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s      = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            cand_req_s  = arbiter_req[cand_s];
            grant_hit_s = grant_hit_s | cand_req_s;
            grant_idx_s = cand_req_s ? cand_s : grant_idx_s;
        end
    end

    // The grant is one-hot and is suppressed while the pipe is frozen.
    always_comb begin
        arbiter_grant = '0;
        if (grant_fire_s) begin
            arbiter_grant = ONE_HOT_LSB << grant_idx_s;
        end else begin
            arbiter_grant = '0;
        end
    end

    assign operand_s = resource_input[int'(grant_idx_s)*DATA_W +: DATA_W];

    // Stage pipe and arbitration pointer.  Payloads move only behind a valid
    // stage, so the output holds its last result while no result is valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r  <= '0;
            rr_ptr_r <= RR_RESET;
            for (int k = 0; k < LATENCY; k++) begin
                id_r[k]   <= '0;
                data_r[k] <= '0;
            end
        end else if (advance_s) begin
            valid_r[0] <= grant_fire_s;
            if (grant_fire_s) begin
                id_r[0]   <= grant_idx_s;
                data_r[0] <= operand_s + DATA_ONE;
                rr_ptr_r  <= grant_idx_s;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    id_r[k]   <= id_r[k-1];
                    data_r[k] <= data_r[k-1];
                end
            end
        end
    end

    assign resource_output = data_r[LATENCY-1];
    assign resp_id         = id_r[LATENCY-1];
    assign resp_valid      = valid_r[LATENCY-1];
    assign busy            = |valid_r;

endmodule
